// File: rtl/traffic_monitor_p_pkg.sv
// Shared types and the mode decoder for the sliding-window traffic monitor.
package tm_p_pkg;

    typedef enum logic [1:0] {
        TM_TOTAL = 2'd0,
        TM_READ  = 2'd1,
        TM_WRITE = 2'd2,
        TM_THRU  = 2'd3
    } tm_mode_e;

    typedef enum logic {
        TM_CLEAR = 1'b0,
        TM_RUN   = 1'b1
    } tm_state_e;

    // Returns {sample_enable, new_bit} for one channel in the given mode.
    function automatic logic [1:0] tm_decode(input tm_mode_e mode,
                                             input logic     mnext,
                                             input logic     mact,
                                             input logic     mcmd);
        logic [1:0] sn;
        case (mode)
            TM_TOTAL: sn = {1'b1, mnext & mact};
            TM_READ:  sn = {1'b1, mnext & mact & mcmd};
            TM_WRITE: sn = {1'b1, mnext & mact & ~mcmd};
            TM_THRU:  sn = {mact, mnext & mact};
            default:  sn = 2'b00;
        endcase
        return sn;
    endfunction

endpackage

// File: rtl/traffic_monitor_p_if.sv
// Channel handshake strobes observed by the traffic monitor.
interface traffic_monitor_p_if
    import tm_p_pkg::*;
#(
    parameter int NCH = 8
) ();
    logic [NCH-1:0] MNEXT;
    logic [NCH-1:0] MACT;
    logic [NCH-1:0] MCMD;

    modport master (output MNEXT, output MACT, output MCMD);
    modport slave  (input  MNEXT, input  MACT, input  MCMD);
endinterface

// File: rtl/traffic_monitor_p_chan.sv
// One monitored channel: history RAM sweep/ring pointer, window count,
// peak hold and sticky threshold alarm.
module tm_chan
    import tm_p_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    mode_i,
    input  logic [AW-1:0] win_i,
    input  logic          restart_i,
    input  logic [AW:0]   thresh_i,
    input  logic          alarm_clr_i,
    input  logic          mnext_i,
    input  logic          mact_i,
    input  logic          mcmd_i,
    output logic [AW:0]   cnt_o,
    output logic [AW:0]   peak_o,
    output logic          ready_o,
    output logic          alarm_o
);
    localparam int            CW       = AW + 1;
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    tm_state_e     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] peak_q, peak_d;
    logic          alarm_q, alarm_d;
    logic          pend_q, pend_d;
    logic          nbit_q, nbit_d;
    logic          obit_q;
    logic          we_s, wbit_s;
    logic          samp_s, newbit_s;
    logic          mem_q [0:(2**AW)-1];

    // Mode decode of the handshake strobes into sample enable and new bit.
    always_comb begin
        {samp_s, newbit_s} = tm_decode(tm_mode_e'(mode_i), mnext_i, mact_i, mcmd_i);
    end

    // Next state, pointer and RAM write control; RESTART overrides everything.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_s    = 1'b0;
        wbit_s  = 1'b0;
        pend_d  = 1'b0;
        nbit_d  = nbit_q;
        if (restart_i) begin
            state_d = TM_CLEAR;
            ptr_d   = PTR_ZERO;
        end else begin
            case (state_q)
                TM_CLEAR: begin
                    we_s = 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_d = TM_RUN;
                        ptr_d   = PTR_ZERO;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end
                TM_RUN: begin
                    if (samp_s) begin
                        we_s   = 1'b1;
                        wbit_s = newbit_s;
                        pend_d = 1'b1;
                        nbit_d = newbit_s;
                        // A pointer beyond a shrunken window runs on to the
                        // natural wrap; software restarts for an exact count.
                        if (ptr_q == win_i) begin
                            ptr_d = PTR_ZERO;
                        end else begin
                            ptr_d = ptr_q + PTR_ONE;
                        end
                    end else begin
                        ptr_d = ptr_q;
                    end
                end
                default: begin
                    state_d = TM_CLEAR;
                    ptr_d   = PTR_ZERO;
                end
            endcase
        end
    end

    // Count, peak and alarm update from the pipelined old/new history bits.
    always_comb begin
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        alarm_d = alarm_q;
        if (restart_i) begin
            cnt_d  = CNT_ZERO;
            peak_d = CNT_ZERO;
        end else begin
            if (pend_q) begin
                cnt_d = cnt_q - {{AW{1'b0}}, obit_q} + {{AW{1'b0}}, nbit_q};
            end else begin
                cnt_d = cnt_q;
            end
            if ((state_q == TM_RUN) && (cnt_q > peak_q)) begin
                peak_d = cnt_q;
            end else begin
                peak_d = peak_q;
            end
        end
        // Set wins over a simultaneous clear.
        if ((state_q == TM_RUN) && (thresh_i != CNT_ZERO) && (cnt_q >= thresh_i)) begin
            alarm_d = 1'b1;
        end else if (alarm_clr_i) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TM_CLEAR;
            ptr_q   <= PTR_ZERO;
            cnt_q   <= CNT_ZERO;
            peak_q  <= CNT_ZERO;
            alarm_q <= 1'b0;
            pend_q  <= 1'b0;
            nbit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
            alarm_q <= alarm_d;
            pend_q  <= pend_d;
            nbit_q  <= nbit_d;
        end
    end

    // History RAM with read-old-data behaviour on the shared address.
    always_ff @(posedge clk_i) begin
        if (we_s) begin
            mem_q[ptr_q] <= wbit_s;
        end
        obit_q <= mem_q[ptr_q];
    end

    assign cnt_o   = cnt_q;
    assign peak_o  = peak_q;
    assign ready_o = (state_q == TM_RUN);
    assign alarm_o = alarm_q;

endmodule

// File: rtl/traffic_monitor_p.sv
// Multi-channel sliding-window traffic monitor: per-channel engines plus
// registered readback mux and interrupt.
module traffic_monitor_p
    import tm_p_pkg::*;
#(
    parameter  int NCH = 8,
    parameter  int AW  = 14,
    localparam int CW  = AW + 1,
    localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2*NCH-1:0]  MODE,
    input  logic [AW-1:0]     WIN,
    input  logic [NCH-1:0]    RESTART,
    input  logic [CW-1:0]     THRESH,
    input  logic [NCH-1:0]    ALARM_CLR,
    input  logic [SW-1:0]     SEL,
    traffic_monitor_p_if.slave bus,
    output logic [CW-1:0]     CNT_O,
    output logic [CW-1:0]     PEAK_O,
    output logic [NCH-1:0]    READY_O,
    output logic [NCH-1:0]    ALARM_O,
    output logic              IRQ
);
    logic [CW-1:0] cnt_s  [NCH];
    logic [CW-1:0] peak_s [NCH];
    logic [CW-1:0] cnt_rd_s, peak_rd_s;
    logic [CW-1:0] cnt_rd_q, peak_rd_q;
    logic          irq_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        tm_chan #(.AW(AW)) u_chan (
            .clk_i       (CLK),
            .rst_ni      (RST),
            .mode_i      (MODE[2*g +: 2]),
            .win_i       (WIN),
            .restart_i   (RESTART[g]),
            .thresh_i    (THRESH),
            .alarm_clr_i (ALARM_CLR[g]),
            .mnext_i     (bus.MNEXT[g]),
            .mact_i      (bus.MACT[g]),
            .mcmd_i      (bus.MCMD[g]),
            .cnt_o       (cnt_s[g]),
            .peak_o      (peak_s[g]),
            .ready_o     (READY_O[g]),
            .alarm_o     (ALARM_O[g])
        );
    end

    // Readback select; a SEL with no matching channel yields zero.
    always_comb begin
        cnt_rd_s  = {CW{1'b0}};
        peak_rd_s = {CW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            cnt_rd_s  = cnt_rd_s  | ((int'(SEL) == i) ? cnt_s[i]  : {CW{1'b0}});
            peak_rd_s = peak_rd_s | ((int'(SEL) == i) ? peak_s[i] : {CW{1'b0}});
        end
    end

    // Registered readback and interrupt.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_rd_q  <= {CW{1'b0}};
            peak_rd_q <= {CW{1'b0}};
            irq_q     <= 1'b0;
        end else begin
            cnt_rd_q  <= cnt_rd_s;
            peak_rd_q <= peak_rd_s;
            irq_q     <= |ALARM_O;
        end
    end

    assign CNT_O  = cnt_rd_q;
    assign PEAK_O = peak_rd_q;
    assign IRQ    = irq_q;

endmodule

// File: tb/tb_traffic_monitor_p.sv
// Self-checking bench for traffic_monitor_p with AW=4, NCH=4.
module tb_traffic_monitor_p;
    localparam int NCH   = 4;
    localparam int AW    = 4;
    localparam int CW    = AW + 1;
    localparam int SW    = 2;
    localparam int DEPTH = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic [2*NCH-1:0] MODE;
    logic [AW-1:0]    WIN;
    logic [NCH-1:0]   RESTART;
    logic [CW-1:0]    THRESH;
    logic [NCH-1:0]   ALARM_CLR;
    logic [SW-1:0]    SEL;
    logic [CW-1:0]    CNT_O;
    logic [CW-1:0]    PEAK_O;
    logic [NCH-1:0]   READY_O;
    logic [NCH-1:0]   ALARM_O;
    logic             IRQ;

    traffic_monitor_p_if #(.NCH(NCH)) bus_if ();

    traffic_monitor_p #(.NCH(NCH), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .MODE      (MODE),
        .WIN       (WIN),
        .RESTART   (RESTART),
        .THRESH    (THRESH),
        .ALARM_CLR (ALARM_CLR),
        .SEL       (SEL),
        .bus       (bus_if),
        .CNT_O     (CNT_O),
        .PEAK_O    (PEAK_O),
        .READY_O   (READY_O),
        .ALARM_O   (ALARM_O),
        .IRQ       (IRQ)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [NCH-1:0][CW-1:0] cnt;
        logic [NCH-1:0][CW-1:0] peak;
        logic [NCH-1:0]         chk;
    } sb_item_t;
    sb_item_t sbq[$];

    // Reference model: explicit history ring, count as popcount of window.
    logic [DEPTH-1:0] mhist [NCH];
    int               mptr  [NCH];
    bit               mrun  [NCH];
    int               mpeak [NCH];
    logic [NCH-1:0]   mready;

    typedef struct {
        int ch; int mode; int win; bit mact; bit mnext; bit tog; bit mcmd0;
        int exp_cnt; int exp_peak;
    } vec_t;
    vec_t vt[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_push();
        sb_item_t         it;
        sb_item_t         last;
        int               s, n, c;
        logic [DEPTH-1:0] mask;
        logic [1:0]       md;
        mask = (WIN == 4'd15) ? 16'hFFFF : ((16'h0001 << (int'(WIN) + 1)) - 16'h0001);
        it = '0;
        // A restart discards the update still in flight for that channel.
        if (sbq.size() > 0 && RESTART != 4'b0000) begin
            last = sbq.pop_back();
            last.chk = last.chk & ~RESTART;
            sbq.push_back(last);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            md = MODE[2*ch +: 2];
            case (md)
                2'd0:    begin s = 1; n = int'(bus_if.MNEXT[ch] & bus_if.MACT[ch]); end
                2'd1:    begin s = 1; n = int'(bus_if.MNEXT[ch] & bus_if.MACT[ch] & bus_if.MCMD[ch]); end
                2'd2:    begin s = 1; n = int'(bus_if.MNEXT[ch] & bus_if.MACT[ch] & ~bus_if.MCMD[ch]); end
                default: begin s = int'(bus_if.MACT[ch]); n = int'(bus_if.MNEXT[ch] & bus_if.MACT[ch]); end
            endcase
            if (RESTART[ch]) begin
                mrun[ch] = 0; mptr[ch] = 0; mpeak[ch] = 0;
            end else if (!mrun[ch]) begin
                mhist[ch][mptr[ch]] = 1'b0;
                if (mptr[ch] == DEPTH - 1) begin mrun[ch] = 1; mptr[ch] = 0; end
                else mptr[ch] = mptr[ch] + 1;
            end else if (s != 0) begin
                mhist[ch][mptr[ch]] = n[0];
                mptr[ch] = (mptr[ch] == int'(WIN)) ? 0 : mptr[ch] + 1;
            end
            c = mrun[ch] ? $countones(mhist[ch] & mask) : 0;
            it.cnt[ch]  = c[CW-1:0];
            it.peak[ch] = mpeak[ch][CW-1:0];
            it.chk[ch]  = 1'b1;
            if (c > mpeak[ch]) mpeak[ch] = c;
            mready[ch] = mrun[ch];
        end
        sbq.push_back(it);
    endtask

    // One clock: model the cycle, advance, then compare ready and due readback.
    task automatic step();
        sb_item_t it;
        model_push();
        @(posedge CLK);
        #1;
        check("ready", int'(READY_O), int'(mready));
        if (sbq.size() == 3) begin
            it = sbq.pop_front();
            if (it.chk[SEL]) begin
                check("sb_cnt", int'(CNT_O), int'(it.cnt[SEL]));
                check("sb_peak", int'(PEAK_O), int'(it.peak[SEL]));
            end
        end
    endtask

    task automatic traffic_off();
        bus_if.MNEXT = 4'b0000; bus_if.MACT = 4'b0000; bus_if.MCMD = 4'b0000;
    endtask

    task automatic restart_all(input int win, input logic [2*NCH-1:0] mode, input int sel);
        WIN = win[AW-1:0]; MODE = mode; SEL = sel[SW-1:0];
        traffic_off();
        RESTART = 4'b1111;
        step();
        RESTART = 4'b0000;
        repeat (DEPTH) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        bit found;
        vt[0] = '{0, 0, 7,  1'b1, 1'b1, 1'b0, 1'b0, 8, 8};
        vt[1] = '{1, 1, 15, 1'b1, 1'b1, 1'b1, 1'b0, 8, 8};
        vt[2] = '{1, 2, 15, 1'b1, 1'b1, 1'b1, 1'b0, 8, 8};
        vt[3] = '{2, 3, 3,  1'b1, 1'b1, 1'b0, 1'b0, 4, 4};
        vt[4] = '{3, 0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
        vt[5] = '{3, 0, 15, 1'b1, 1'b1, 1'b0, 1'b0, 16, 16};
        vt[6] = '{2, 1, 7,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        vt[7] = '{0, 2, 7,  1'b1, 1'b1, 1'b0, 1'b0, 8, 8};
        vt[8] = '{0, 0, 7,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0};

        for (int ch = 0; ch < NCH; ch++) begin
            mhist[ch] = 16'hFFFF; mptr[ch] = 0; mrun[ch] = 0; mpeak[ch] = 0;
        end
        mready = 4'b0000;

        // Reset state.
        RST = 1'b0; MODE = 8'h00; WIN = 4'd0; RESTART = 4'b0000; THRESH = 5'd0;
        ALARM_CLR = 4'b0000; SEL = 2'd0;
        traffic_off();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cnt", int'(CNT_O), 0);
        check("rst_peak", int'(PEAK_O), 0);
        check("rst_ready", int'(READY_O), 0);
        check("rst_alarm", int'(ALARM_O), 0);
        check("rst_irq", int'(IRQ), 0);
        RST = 1'b1;
        repeat (DEPTH - 1) step();
        check("sweep_ready_lo", int'(READY_O), 0);
        step();
        check("sweep_ready_hi", int'(READY_O), 15);
        check("sweep_cnt", int'(CNT_O), 0);

        // Mode/window vectors.
        for (int r = 0; r < 9; r++) begin
            logic [2*NCH-1:0] md;
            md = 8'h00;
            md[2*vt[r].ch +: 2] = vt[r].mode[1:0];
            restart_all(vt[r].win, md, vt[r].ch);
            for (int k = 0; k < 24; k++) begin
                bus_if.MACT[vt[r].ch]  = vt[r].mact;
                bus_if.MNEXT[vt[r].ch] = vt[r].mnext;
                bus_if.MCMD[vt[r].ch]  = vt[r].tog ? k[0] : vt[r].mcmd0;
                step();
            end
            check($sformatf("vec%0d_cnt", r), int'(CNT_O), vt[r].exp_cnt);
            check($sformatf("vec%0d_peak", r), int'(PEAK_O), vt[r].exp_peak);
        end

        // Throughput mode holds its count while the channel is idle.
        restart_all(3, 8'b0011_0000, 2);
        bus_if.MACT[2] = 1'b1; bus_if.MNEXT[2] = 1'b1;
        repeat (10) step();
        check("thru_cnt", int'(CNT_O), 4);
        bus_if.MACT[2] = 1'b0;
        repeat (20) step();
        check("thru_hold_cnt", int'(CNT_O), 4);
        check("thru_hold_peak", int'(PEAK_O), 4);

        // Alarm set at threshold, sticky clear, IRQ lag.
        THRESH = 5'd5;
        restart_all(7, 8'h00, 0);
        bus_if.MACT[0] = 1'b1; bus_if.MNEXT[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = ALARM_O[0];
        end
        check("alarm_set_seen", int'(found), 1);
        check("alarm_cnt_at_set", int'(CNT_O), 5);
        check("irq_lag", int'(IRQ), 0);
        step();
        check("irq_set", int'(IRQ), 1);
        repeat (5) step();
        ALARM_CLR = 4'b0001;
        step();
        ALARM_CLR = 4'b0000;
        check("alarm_set_beats_clr", int'(ALARM_O[0]), 1);
        bus_if.MNEXT[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = (CNT_O < 5'd5);
        end
        check("drain_seen", int'(found), 1);
        check("alarm_sticky", int'(ALARM_O[0]), 1);
        repeat (2) step();
        ALARM_CLR = 4'b0001;
        step();
        ALARM_CLR = 4'b0000;
        check("alarm_cleared", int'(ALARM_O[0]), 0);
        step();
        check("irq_cleared", int'(IRQ), 0);
        THRESH = 5'd0;
        bus_if.MNEXT[0] = 1'b1;
        repeat (12) step();
        check("thresh0_cnt", int'(CNT_O), 8);
        check("thresh0_no_alarm", int'(ALARM_O), 0);

        // Restart one channel mid-run; the others keep counting.
        restart_all(7, 8'h00, 0);
        bus_if.MACT = 4'b1111; bus_if.MNEXT = 4'b1111;
        repeat (12) step();
        check("pre_restart_cnt", int'(CNT_O), 8);
        RESTART = 4'b0001;
        step();
        RESTART = 4'b0000;
        check("restart_ready", int'(READY_O), 14);
        step();
        check("restart_cnt", int'(CNT_O), 0);
        check("restart_peak", int'(PEAK_O), 0);
        SEL = 2'd1;
        for (int k = 0; k < 15; k++) begin
            step();
            check($sformatf("restart_ready0_k%0d", k), int'(READY_O[0]), (k == 14) ? 1 : 0);
        end
        check("other_cnt", int'(CNT_O), 8);
        check("other_peak", int'(PEAK_O), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_monitor_p.md
Name: traffic_monitor_p

Overview:
Parametrised multi-channel sliding-window traffic monitor for memory/bus channels. It is the successor to the fixed 8-channel, 14-bit monitor.
- Per channel: keeps a 1-bit event history in a RAM of depth 2^AW and a running count of events over the last WIN+1 samples.
- Adds peak-hold, per-channel threshold alarms with IRQ, a selectable readback port, and a widened counter that cannot overflow.
- Sits beside the CPU control-register block and samples channel handshake strobes.

Parameters:
NCH, 8, number of monitored channels (1..32)
AW, 14, log2 of history depth; maximum window is 2^AW samples
CW, AW+1, counter/peak width (fixed derivation, not overridable)
SW, $clog2(NCH) (min 1), readback select width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
MODE  in  2*NCH  per-channel mode, MODE[2i+1:2i]
WIN  in  AW  window length minus 1, common to all channels
RESTART  in  NCH  per-channel restart pulse
THRESH  in  CW  common alarm threshold; 0 disables alarms
ALARM_CLR  in  NCH  per-channel sticky-alarm clear
SEL  in  SW  readback channel select
MNEXT  in  NCH  transfer accepted strobe
MACT  in  NCH  channel active
MCMD  in  NCH  1 = read, 0 = write
CNT_O  out  CW  window count of channel SEL
PEAK_O  out  CW  peak count of channel SEL
READY_O  out  NCH  window-valid flag per channel
ALARM_O  out  NCH  sticky alarm per channel
IRQ  out  1  OR of ALARM_O, registered

Behaviour:
- Reset:
  - All outputs 0.
  - Every channel enters CLEAR with ptr = 0, cnt = 0, peak = 0.
- Per-channel states:
  - CLEAR: every cycle, write 0 at ptr, ptr += 1.
    - When ptr == 2^AW-1: write, then go to RUN with ptr = 0.
    - The CLEAR sweep takes exactly 2^AW cycles.
  - RUN: READY_O[i] = 1.
- Mode decode (MODE bits, sample enable s, new bit n):
  - 0 total: s = 1, n = MNEXT&MACT.
  - 1 read: s = 1, n = MNEXT&MACT&MCMD.
  - 2 write: s = 1, n = MNEXT&MACT&~MCMD.
  - 3 throughput: s = MACT, n = MNEXT&MACT.
- RUN sample at cycle t (s = 1):
  - Write n at ptr; RAM returns the old bit o at the same address (read-old-data).
  - ptr wraps to 0 when ptr == WIN, else ptr += 1.
- RUN without a sample (s = 0): ptr, RAM and cnt are unchanged.
- Count update: cnt <= cnt - o + n at edge t+1, visible at t+2. Width is CW, so no saturation is needed (cnt <= 2^AW).
- Peak: at edge t+2, peak <= max(peak, cnt). Cleared only by reset or RESTART.
- Alarm:
  - ALARM_O[i] set when READY, THRESH != 0 and cnt >= THRESH.
  - Sticky; cleared by ALARM_CLR[i].
  - Set has priority over a simultaneous clear.
- IRQ = registered |ALARM_O, one cycle after ALARM_O.
- Readback: CNT_O and PEAK_O are registered from channel SEL, one cycle latency. SEL values >= NCH return 0.
- RESTART[i], any state: next cycle the channel is in CLEAR with ptr = 0, cnt = 0, peak = 0, READY = 0.
  - In-flight pipeline updates are discarded.
  - ALARM_O is unaffected.
  - RESTART during CLEAR restarts the sweep.
- WIN or MODE change in RUN: no correction is applied.
  - If ptr > new WIN, ptr advances to 2^AW-1 then wraps to 0.
  - Software must RESTART for an exact count.
- WIN = 0 gives a one-sample window; WIN = 2^AW-1 gives a full-depth window.
- Channels are fully independent; there is no cross-channel arbitration.

Decomposition:
- Package tm_p_pkg:
  - enum tm_mode_e {TM_TOTAL, TM_READ, TM_WRITE, TM_THRU};
  - enum tm_state_e {TM_CLEAR, TM_RUN}.
- Sub-module tm_chan: one channel containing state, ptr, inferred 2^AW x 1 RAM, cnt, peak and alarm. Generated NCH times.
- Top level holds only the readback mux and IRQ register.

Test Plan:
- AW=4, NCH=4: after reset, hold inputs 0 -> READY_O = 0 for 16 cycles, READY_O = 4'hF on cycle 17; CNT_O = 0.
- Ch0 mode 0, WIN=7, MNEXT=MACT=1 constant -> CNT_O (SEL=0) climbs 1..8, then holds 8; PEAK_O = 8.
- Ch1 mode 1, WIN=15, MACT=MNEXT=1, MCMD toggling each cycle -> CNT_O (SEL=1) settles at 8.
- Ch2 mode 3, WIN=3, MACT=0 for 20 cycles after a count of 4 -> CNT_O holds 4 (no samples consumed).
- THRESH=5, ch0 reaches 8 -> ALARM_O[0] = 1, IRQ one cycle later. ALARM_CLR[0] while cnt >= 5 -> alarm stays 1. Stop traffic until cnt < 5, then ALARM_CLR -> 0.
- RESTART[0] mid-RUN with cnt = 8 -> next cycle READY_O[0] = 0, CNT_O = 0, PEAK_O = 0; READY_O[0] returns after 16 cycles; other channels unaffected.
